prog_sequence_generator: RTL and testbench



---
 rtl/prog_sequence_generator.sv | 185 ++++++++++++++++++
 tb/tb_prog_sequence_generator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequence_generator.sv
// Programmable pattern sequencer: DEPTH x WIDTH table stepped in
// one-shot, loop or ping-pong order under a step enable.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   wr_en/wr_addr/wr_data table write port (any state)
//   seq_len, mode        last index and mode, latched on start
//   start, stop, step_en sequence control (stop > start > step)
//   seq_out, seq_valid   current registered table word
//   busy, index          running flag and current index
//   done, wrap           one-cycle completion / wrap pulses
module prog_sequence_generator #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    seq_len,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    input  logic             step_en,
    output logic [WIDTH-1:0] seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic [AW-1:0]    index,
    output logic             done,
    output logic             wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t           r_state;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic [AW-1:0]    r_last;
    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic             r_done;
    logic             r_wrap;
    logic [WIDTH-1:0] r_mem [DEPTH];

    state_t           w_state_nx;
    logic             w_dir_nx;
    logic [1:0]       w_mode_nx;
    logic [AW-1:0]    w_last_nx;
    logic [AW-1:0]    w_idx_nx;
    logic [WIDTH-1:0] w_out_nx;
    logic             w_valid_nx;
    logic             w_done_nx;
    logic             w_wrap_nx;
    logic             w_load;
    logic [AW-1:0]    w_last_clip;
    logic             w_at_last;

    assign w_last_clip = (seq_len > LAST_MAX) ? LAST_MAX : seq_len;
    assign w_at_last   = (r_idx == r_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_mode  <= 2'b00;
            r_last  <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_dir   <= w_dir_nx;
            r_mode  <= w_mode_nx;
            r_last  <= w_last_nx;
            r_idx   <= w_idx_nx;
            r_out   <= w_out_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
            r_wrap  <= w_wrap_nx;
        end
    end

    // Table: the read path uses the pre-edge contents, so a same-edge
    // write to the entry being loaded is seen only on the next visit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_mode_nx  = r_mode;
        w_last_nx  = r_last;
        w_idx_nx   = r_idx;
        w_out_nx   = r_out;
        w_valid_nx = r_valid;
        w_done_nx  = 1'b0;
        w_wrap_nx  = 1'b0;
        w_load     = 1'b0;
        if (stop) begin
            w_state_nx = IDLE;
            w_dir_nx   = 1'b0;
            w_idx_nx   = '0;
            w_out_nx   = '0;
            w_valid_nx = 1'b0;
        end else if (start) begin
            w_state_nx = RUN;
            w_dir_nx   = 1'b0;
            w_mode_nx  = mode;
            w_last_nx  = w_last_clip;
            w_idx_nx   = '0;
            w_load     = 1'b1;
        end else if (r_state == RUN && step_en) begin
            w_load = 1'b1;
            unique case (r_mode)
                2'b00: begin
                    if (w_at_last) begin
                        w_state_nx = IDLE;
                        w_idx_nx   = '0;
                        w_out_nx   = '0;
                        w_valid_nx = 1'b0;
                        w_done_nx  = 1'b0 | 1'b1;
                        w_load     = 1'b0;
                    end else begin
                        w_idx_nx = r_idx + ONE;
                    end
                end
                2'b10: begin
                    // r_dir: 0 = counting up, 1 = counting down
                    if (!r_dir) begin
                        if (w_at_last) begin
                            w_dir_nx  = 1'b1;
                            w_wrap_nx = 1'b1;
                            w_idx_nx  = (r_last == '0) ? '0 : r_idx - ONE;
                        end else begin
                            w_idx_nx = r_idx + ONE;
                        end
                    end else begin
                        if (r_idx == '0) begin
                            w_dir_nx  = 1'b0;
                            w_wrap_nx = 1'b1;
                            w_idx_nx  = (r_last == '0) ? '0 : ONE;
                        end else begin
                            w_idx_nx = r_idx - ONE;
                        end
                    end
                end
                default: begin
                    if (w_at_last) begin
                        w_idx_nx  = '0;
                        w_wrap_nx = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + ONE;
                    end
                end
            endcase
        end
        if (w_load) begin
            w_out_nx   = r_mem[w_idx_nx];
            w_valid_nx = 1'b1;
        end
    end

    assign seq_out   = r_out;
    assign seq_valid = r_valid;
    assign busy      = (r_state == RUN);
    assign index     = r_idx;
    assign done      = r_done;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_prog_sequence_generator.sv
// Scoreboard bench for prog_sequence_generator (WIDTH=4, DEPTH=6).
// Stimulus pushes expected post-edge outputs; a monitor checks them.
module tb_prog_sequence_generator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [2:0] seq_len;
    logic [1:0] mode;
    logic       start;
    logic       stop;
    logic       step_en;
    logic [3:0] seq_out;
    logic       seq_valid;
    logic       busy;
    logic [2:0] index;
    logic       done;
    logic       wrap;

    prog_sequence_generator #(
        .WIDTH(4),
        .DEPTH(6)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .seq_len  (seq_len),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .step_en  (step_en),
        .seq_out  (seq_out),
        .seq_valid(seq_valid),
        .busy     (busy),
        .index    (index),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] o;
        logic       v;
        logic       b;
        logic [2:0] i;
        logic       d;
        logic       w;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic push(input logic [3:0] o, input logic v, input logic b,
                        input logic [2:0] i, input logic d, input logic w,
                        input string nm);
        exp_t e;
        e.o = o; e.v = v; e.b = b; e.i = i; e.d = d; e.w = w; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic cyc(input logic st, input logic sp, input logic en,
                       input logic we, input logic [2:0] wa,
                       input logic [3:0] wd, input logic [3:0] o,
                       input logic v, input logic b, input logic [2:0] i,
                       input logic d, input logic w, input string nm);
        #1;
        start   = st;
        stop    = sp;
        step_en = en;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        push(o, v, b, i, d, w, nm);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        cyc(0, 0, 0, 1, a, d, 4'd0, 0, 0, 3'd0, 0, 0, "idle_wr");
    endtask

    task automatic go(input logic [3:0] o, input string nm);
        cyc(1, 0, 1, 0, 3'd0, 4'd0, o, 1, 1, 3'd0, 0, 0, nm);
    endtask

    task automatic st(input logic [3:0] o, input logic [2:0] i,
                      input logic w, input string nm);
        cyc(0, 0, 1, 0, 3'd0, 4'd0, o, 1, 1, i, 0, w, nm);
    endtask

    task automatic hold(input logic [3:0] o, input logic [2:0] i,
                        input string nm);
        cyc(0, 0, 0, 0, 3'd0, 4'd0, o, 1, 1, i, 0, 0, nm);
    endtask

    task automatic idle(input logic d, input string nm);
        cyc(0, 0, 1, 0, 3'd0, 4'd0, 4'd0, 0, 0, 3'd0, d, 0, nm);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_run++;
            if (seq_out !== e.o || seq_valid !== e.v || busy !== e.b ||
                index !== e.i || done !== e.d || wrap !== e.w) begin
                n_fail++;
                $display("FAIL %s: got out=%0d v=%0b busy=%0b idx=%0d done=%0b wrap=%0b, want out=%0d v=%0b busy=%0b idx=%0d done=%0b wrap=%0b",
                         e.nm, seq_out, seq_valid, busy, index, done, wrap,
                         e.o, e.v, e.b, e.i, e.d, e.w);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        seq_len = 0; mode = 0;
        start = 0; stop = 0; step_en = 0;
        @(posedge clk);
        push(4'd0, 0, 0, 3'd0, 0, 0, "reset");
        #1 reset_n = 1'b1;

        // Loop over 3,6,1,4
        wr(0, 4'd3); wr(1, 4'd6); wr(2, 4'd1); wr(3, 4'd4);
        mode = 2'b01; seq_len = 3'd3;
        go(4'd3, "loop_start");
        st(4'd6, 1, 0, "loop1");
        st(4'd1, 2, 0, "loop2");
        st(4'd4, 3, 0, "loop3");
        st(4'd3, 0, 1, "loop_wrap");
        st(4'd6, 1, 0, "loop_again");

        // One-shot, restarted from a running loop
        mode = 2'b00; seq_len = 3'd2;
        go(4'd3, "os_restart");
        st(4'd6, 1, 0, "os1");
        st(4'd1, 2, 0, "os_final");
        idle(1, "os_done");
        idle(0, "os_done_clear");

        // Ping-pong over 1..5
        wr(0, 4'd1); wr(1, 4'd2); wr(2, 4'd3); wr(3, 4'd4); wr(4, 4'd5);
        mode = 2'b10; seq_len = 3'd4;
        go(4'd1, "pp_start");
        st(4'd2, 1, 0, "pp1");
        st(4'd3, 2, 0, "pp2");
        st(4'd4, 3, 0, "pp3");
        st(4'd5, 4, 0, "pp_top");
        st(4'd4, 3, 1, "pp_rev_top");
        st(4'd3, 2, 0, "pp_dn2");
        st(4'd2, 1, 0, "pp_dn1");
        st(4'd1, 0, 0, "pp_bot");
        st(4'd2, 1, 1, "pp_rev_bot");
        st(4'd3, 2, 0, "pp_up2");

        // Step enable gating, then start+stop together
        mode = 2'b01; seq_len = 3'd4;
        go(4'd1, "gate_start");
        st(4'd2, 1, 0, "gate_step");
        hold(4'd2, 1, "gate_hold1");
        hold(4'd2, 1, "gate_hold2");
        st(4'd3, 2, 0, "gate_resume");
        cyc(1, 1, 1, 0, 3'd0, 4'd0, 4'd0, 0, 0, 3'd0, 0, 0, "start_stop");
        idle(0, "after_stop");

        // Read-before-write and out-of-range writes
        go(4'd1, "rbw_start");
        st(4'd2, 1, 0, "rbw1");
        st(4'd3, 2, 0, "rbw2");
        cyc(0, 0, 1, 1, 3'd3, 4'd9, 4'd4, 1, 1, 3'd3, 0, 0, "rbw_old");
        st(4'd5, 4, 0, "rbw4");
        st(4'd1, 0, 1, "rbw_wrap");
        st(4'd2, 1, 0, "rbw_p1");
        st(4'd3, 2, 0, "rbw_p2");
        st(4'd9, 3, 0, "rbw_new");
        cyc(0, 0, 0, 1, 3'd6, 4'd15, 4'd9, 1, 1, 3'd3, 0, 0, "oor_wr6");
        cyc(0, 0, 0, 1, 3'd7, 4'd15, 4'd9, 1, 1, 3'd3, 0, 0, "oor_wr7");
        st(4'd5, 4, 0, "oor_e4");
        st(4'd1, 0, 1, "oor_e0");

        // Stop while running, stop while idle
        cyc(0, 1, 1, 0, 3'd0, 4'd0, 4'd0, 0, 0, 3'd0, 0, 0, "stop_run");
        cyc(0, 1, 1, 0, 3'd0, 4'd0, 4'd0, 0, 0, 3'd0, 0, 0, "stop_idle");

        // last = 0 in every mode
        seq_len = 3'd0;
        mode = 2'b01;
        go(4'd1, "l0_loop");
        st(4'd1, 0, 1, "l0_loop_w1");
        st(4'd1, 0, 1, "l0_loop_w2");
        mode = 2'b00;
        go(4'd1, "l0_os");
        idle(1, "l0_os_done");
        mode = 2'b10;
        go(4'd1, "l0_pp");
        st(4'd1, 0, 1, "l0_pp_w1");
        st(4'd1, 0, 1, "l0_pp_w2");
        mode = 2'b11;
        seq_len = 3'd1;
        go(4'd1, "m11_start");
        st(4'd2, 1, 0, "m11_1");
        st(4'd1, 0, 1, "m11_wrap");

        // Asynchronous reset mid-run, between clock edges
        mode = 2'b10; seq_len = 3'd4;
        go(4'd1, "ar_start");
        st(4'd2, 1, 0, "ar_run");
        #1 step_en = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        push(4'd0, 0, 0, 3'd0, 0, 0, "async_reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Table cleared; seq_len beyond DEPTH-1 clips to 5
        mode = 2'b01; seq_len = 3'd7;
        go(4'd0, "clip_start");
        st(4'd0, 1, 0, "clip1");
        st(4'd0, 2, 0, "clip2");
        st(4'd0, 3, 0, "clip3");
        st(4'd0, 4, 0, "clip4");
        st(4'd0, 5, 0, "clip5");
        st(4'd0, 0, 1, "clip_wrap");

        #1 step_en = 1'b0;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
